// File: rtl/transmissor_display_pkg.sv
// rtl/transmissor_display_pkg.sv - state encoding and SSD1306 addressing preamble
package transmissor_display_pkg;

  typedef enum logic [1:0] {
    OCIOSO    = 2'd0,
    PREAMBULO = 2'd1,
    DADOS     = 2'd2,
    FIM       = 2'd3
  } estado_t;

  localparam int N_PREAMBULO = 6;

  // Column window 0..127 and page window 0..7: the whole GDDRAM, horizontal order.
  function automatic logic [7:0] cmd_preambulo(input logic [2:0] idx);
    logic [7:0] cmd;
    case (idx)
      3'd0:    cmd = 8'h21;
      3'd1:    cmd = 8'h00;
      3'd2:    cmd = 8'h7F;
      3'd3:    cmd = 8'h22;
      3'd4:    cmd = 8'h00;
      3'd5:    cmd = 8'h07;
      default: cmd = 8'h00;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/transmissor_display_if.sv
// rtl/transmissor_display_if.sv - byte handshake between frame sequencer and SPI serializer
interface transmissor_display_if;

  logic       carregar;
  logic [7:0] dado;
  logic       byte_pronto;
  logic       sclk;
  logic       mosi;

  modport master (output carregar, dado, input byte_pronto, sclk, mosi);
  modport slave  (input carregar, dado, output byte_pronto, sclk, mosi);

endinterface

// File: rtl/transmissor_display_serializador.sv
// rtl/transmissor_display_serializador.sv - SPI mode 0 byte shifter, MSB first, H clk per SCLK half
module serializador_spi #(
  parameter int DIV_SCLK = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  transmissor_display_if.slave lnk
);

  localparam int            DW      = (DIV_SCLK > 1) ? $clog2(DIV_SCLK) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(DIV_SCLK - 1);

  logic [DW-1:0] div_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          sclk_q;
  logic          ativo_q;

  // Pulses on the edge that ends the last high phase, so the next byte loads on that falling edge.
  assign lnk.byte_pronto = ativo_q && sclk_q && (div_q == DIV_MAX) && (bit_q == 3'd0);
  assign lnk.sclk        = sclk_q;
  assign lnk.mosi        = shift_q[7];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      sclk_q  <= 1'b0;
      ativo_q <= 1'b0;
    end else if (lnk.carregar) begin
      div_q   <= '0;
      bit_q   <= 3'd7;
      shift_q <= lnk.dado;
      sclk_q  <= 1'b0;
      ativo_q <= 1'b1;
    end else if (ativo_q) begin
      if (div_q != DIV_MAX) begin
        div_q <= div_q + 1'b1;
      end else begin
        div_q <= '0;
        if (!sclk_q) begin
          sclk_q <= 1'b1;
        end else begin
          sclk_q <= 1'b0;
          if (bit_q == 3'd0) begin
            ativo_q <= 1'b0;
            shift_q <= 8'h00;
          end else begin
            bit_q   <= bit_q - 1'b1;
            shift_q <= {shift_q[6:0], 1'b0};
          end
        end
      end
    end
  end

endmodule

// File: rtl/transmissor_display.sv
// rtl/transmissor_display.sv - snapshots a 128x64 frame and streams preamble + data to an SSD1306 over SPI
module transmissor_display
  import transmissor_display_pkg::*;
#(
  parameter int DIV_SCLK = 4,
  parameter int N_BYTES  = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_BYTES*8-1:0] imagem,
  input  logic                 iniciar,
  output logic                 ocupado,
  output logic                 quadro_enviado,
  output logic                 spi_sclk,
  output logic                 spi_mosi,
  output logic                 spi_cs_n,
  output logic                 spi_dc
);

  localparam int            CW         = $clog2(N_BYTES + N_PREAMBULO);
  localparam int            IW         = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam logic [CW-1:0] ULTIMO     = CW'(N_BYTES + N_PREAMBULO - 1);
  localparam logic [CW-1:0] ULTIMO_CMD = CW'(N_PREAMBULO - 1);

  estado_t       estado_q;
  logic [CW-1:0] byte_q;
  logic [7:0]    quadro_q [N_BYTES];
  logic          ocupado_q;
  logic          enviado_q;
  logic          cs_n_q;
  logic          dc_q;
  logic          aceitar;
  logic          avancar;
  logic [IW-1:0] idx_dado;

  transmissor_display_if lnk ();

  serializador_spi #(.DIV_SCLK(DIV_SCLK)) u_serializador (
    .clk   (clk),
    .rst_n (rst_n),
    .lnk   (lnk.slave)
  );

  assign aceitar  = iniciar && ((estado_q == OCIOSO) || (estado_q == FIM));
  assign avancar  = lnk.byte_pronto && (byte_q != ULTIMO);
  // Frame position p+1 holds data byte p-5 once the preamble is exhausted.
  assign idx_dado = IW'(byte_q - ULTIMO_CMD);

  always_comb begin
    lnk.carregar = aceitar || avancar;
    lnk.dado     = 8'h00;
    if (aceitar)
      lnk.dado = cmd_preambulo(3'd0);
    else if (byte_q < ULTIMO_CMD)
      lnk.dado = cmd_preambulo(3'(byte_q + 1'b1));
    else
      lnk.dado = quadro_q[idx_dado];
  end

  always_ff @(posedge clk) begin
    if (aceitar)
      for (int i = 0; i < N_BYTES; i++)
        quadro_q[i] <= imagem[i*8 +: 8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q  <= OCIOSO;
      byte_q    <= '0;
      ocupado_q <= 1'b0;
      enviado_q <= 1'b0;
      cs_n_q    <= 1'b1;
      dc_q      <= 1'b0;
    end else begin
      enviado_q <= 1'b0;
      case (estado_q)
        OCIOSO, FIM: begin
          estado_q  <= OCIOSO;
          ocupado_q <= 1'b0;
          cs_n_q    <= 1'b1;
          dc_q      <= 1'b0;
          if (iniciar) begin
            estado_q  <= PREAMBULO;
            byte_q    <= '0;
            ocupado_q <= 1'b1;
            cs_n_q    <= 1'b0;
          end
        end
        PREAMBULO: begin
          if (lnk.byte_pronto) begin
            byte_q <= byte_q + 1'b1;
            if (byte_q == ULTIMO_CMD) begin
              estado_q <= DADOS;
              dc_q     <= 1'b1;
            end
          end
        end
        DADOS: begin
          if (lnk.byte_pronto) begin
            if (byte_q == ULTIMO) begin
              estado_q  <= FIM;
              enviado_q <= 1'b1;
              ocupado_q <= 1'b0;
              cs_n_q    <= 1'b1;
              dc_q      <= 1'b0;
            end else begin
              byte_q <= byte_q + 1'b1;
            end
          end
        end
        default: estado_q <= OCIOSO;
      endcase
    end
  end

  assign ocupado        = ocupado_q;
  assign quadro_enviado = enviado_q;
  assign spi_sclk       = lnk.sclk;
  assign spi_mosi       = lnk.mosi;
  assign spi_cs_n       = cs_n_q;
  assign spi_dc         = dc_q;

endmodule
